// File: rtl/decode_scoreboard.sv
// Decode-stage register scoreboard: per-register latency counters that raise
// stall on RAW/WAW hazards and track the number of in-flight writes.
module decode_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_LAT  = 4,
    parameter int LAT_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              rs_used,
    input  logic              rt_used,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_waddr,
    input  logic [LAT_W-1:0]  issue_lat,
    input  logic              freeze,
    input  logic              flush,
    output logic              stall,
    output logic              issue_fire,
    output logic [ADDR_W:0]   busy_count,
    output logic [31:0]       stall_cycles
);

    logic [LAT_W-1:0] cnt     [NUM_REGS];
    logic [LAT_W-1:0] cnt_nxt [NUM_REGS];
    logic [ADDR_W:0]  busy_nxt;
    logic [LAT_W-1:0] eff_lat;
    logic [LAT_W-1:0] rs_cnt;
    logic [LAT_W-1:0] rt_cnt;
    logic [LAT_W-1:0] w_cnt;
    logic             raw_hazard;
    logic             waw_hazard;
    logic             w_tracked;

    function automatic logic tracked(input logic [ADDR_W-1:0] a);
        return (a != '0) && (int'(a) < NUM_REGS);
    endfunction

    always_comb begin
        eff_lat = issue_lat;
        if (issue_lat == '0)
            eff_lat = LAT_W'(1);
        else if (issue_lat > LAT_W'(MAX_LAT))
            eff_lat = LAT_W'(MAX_LAT);
    end

    always_comb begin
        rs_cnt    = '0;
        rt_cnt    = '0;
        w_cnt     = '0;
        w_tracked = tracked(issue_waddr);
        if (tracked(rs_addr))
            rs_cnt = cnt[rs_addr];
        if (tracked(rt_addr))
            rt_cnt = cnt[rt_addr];
        if (w_tracked)
            w_cnt = cnt[issue_waddr];
    end

    // A count of 1 means the result is on the forwarding path this cycle, so
    // only counts above 1 block a reader (L-1 stall cycles for latency L).
    assign raw_hazard = (rs_used && (rs_cnt > LAT_W'(1))) ||
                        (rt_used && (rt_cnt > LAT_W'(1)));
    // The effective (clamped) latency decides whether the new write would
    // complete before the older one still in flight.
    assign waw_hazard = issue_we && w_tracked && (w_cnt > eff_lat);

    assign stall      = issue_valid && !flush && (raw_hazard || waw_hazard);
    assign issue_fire = issue_valid && !stall && !flush && !freeze;

    always_comb begin
        busy_nxt = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_nxt[r] = cnt[r];
            if (r == 0) begin
                cnt_nxt[r] = '0;
            end else begin
                if (!freeze && (cnt[r] != '0))
                    cnt_nxt[r] = cnt[r] - LAT_W'(1);
                if (issue_fire && issue_we && (int'(issue_waddr) == r))
                    cnt_nxt[r] = eff_lat;
                if (cnt_nxt[r] != '0)
                    busy_nxt = busy_nxt + (ADDR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= '0;
            busy_count   <= '0;
            stall_cycles <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= cnt_nxt[r];
            busy_count <= busy_nxt;
            if (stall && !freeze && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule
